// File: rtl/hline_setup_if.sv
// hline_setup_if: span command and line-FSM operand bundle for hline_setup.
interface hline_setup_if;
    logic        start;
    logic        ready;
    logic [10:0] x1;
    logic [10:0] x2;
    logic [9:0]  y;
    logic [31:0] z1_in;
    logic [31:0] z2_in;
    logic [31:0] rgbx_in;
    logic [31:0] fb_base;
    logic [31:0] zbuff_base;
    logic        done_in;
    logic        start_out;
    logic [31:0] fb_addr;
    logic [31:0] zbuff_addr;
    logic [31:0] dx;
    logic [31:0] slope;
    logic [31:0] rem;
    logic [31:0] err;
    logic [31:0] z1;
    logic [31:0] rgbx;
    modport master (
        output start, x1, x2, y, z1_in, z2_in, rgbx_in, fb_base, zbuff_base, done_in,
        input  ready, start_out, fb_addr, zbuff_addr, dx, slope, rem, err, z1, rgbx
    );
    modport slave (
        input  start, x1, x2, y, z1_in, z2_in, rgbx_in, fb_base, zbuff_base, done_in,
        output ready, start_out, fb_addr, zbuff_addr, dx, slope, rem, err, z1, rgbx
    );
endinterface

// File: rtl/hline_setup.sv
// hline_setup: orders a span, divides dz by dx bit-serially and hands operands to the line FSM.
module hline_setup #(
    parameter int LINE_PIXELS = 640,
    parameter int BPP_SHIFT   = 2
) (
    input logic        clk,
    input logic        reset,
    hline_setup_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DIV, WAIT} state_t;
    state_t      state, state_n;
    logic [4:0]  count;
    logic [31:0] dz, part, part_nx, dx_new, pix;
    logic [30:0] quo;
    logic [32:0] part_sh;
    logic [10:0] x_lo, x_hi;
    logic [31:0] z_lo, z_hi;
    logic        swap, ge;
    always_comb begin
        swap    = bus.x2 < bus.x1;
        x_lo    = swap ? bus.x2 : bus.x1;
        x_hi    = swap ? bus.x1 : bus.x2;
        z_lo    = swap ? bus.z2_in : bus.z1_in;
        z_hi    = swap ? bus.z1_in : bus.z2_in;
        dx_new  = 32'(x_hi - x_lo);
        pix     = (32'(bus.y) * 32'(LINE_PIXELS) + 32'(x_lo)) << BPP_SHIFT;
        part_sh = {part, dz[count]};
        ge      = part_sh >= {1'b0, bus.dx};
        part_nx = ge ? 32'(part_sh - {1'b0, bus.dx}) : part_sh[31:0];
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.start ? (dx_new == 32'd0 ? WAIT : DIV) : IDLE;
            DIV:     state_n = count == 5'd0 ? WAIT : DIV;
            WAIT:    state_n = bus.done_in ? IDLE : WAIT;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;
    assign bus.ready = state == IDLE;
    // start_out trails entry into WAIT by one edge so it never precedes stable operands
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.start_out  <= 1'b0;
            bus.fb_addr    <= '0;
            bus.zbuff_addr <= '0;
            bus.dx         <= '0;
            bus.slope      <= '0;
            bus.rem        <= '0;
            bus.err        <= '0;
            bus.z1         <= '0;
            bus.rgbx       <= '0;
            dz             <= '0;
            part           <= '0;
            quo            <= '0;
            count          <= '0;
        end else begin
            bus.start_out <= state == WAIT && !bus.done_in;
            if (state == IDLE && bus.start) begin
                bus.fb_addr    <= bus.fb_base + pix;
                bus.zbuff_addr <= bus.zbuff_base + pix;
                bus.dx         <= dx_new;
                bus.slope      <= '0;
                bus.rem        <= '0;
                bus.err        <= (dx_new + 32'd1) >> 1;
                bus.z1         <= z_lo;
                bus.rgbx       <= bus.rgbx_in;
                dz             <= z_hi - z_lo;
                part           <= '0;
                quo            <= '0;
                count          <= 5'd31;
            end else if (state == DIV) begin
                part  <= part_nx;
                quo   <= {quo[29:0], ge};
                count <= count - 5'd1;
                if (count == 5'd0) begin
                    bus.slope <= {quo, ge};
                    bus.rem   <= part_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_hline_setup.sv
// tb_hline_setup: directed span commands checked against hand-computed operands.
module tb_hline_setup;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    hline_setup_if h();
    hline_setup #(.LINE_PIXELS(640), .BPP_SHIFT(2)) dut (.clk(clk), .reset(reset), .bus(h));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic launch(input logic [10:0] a, input logic [10:0] b, input logic [9:0] yy,
                          input logic [31:0] za, input logic [31:0] zb, input logic [31:0] c,
                          input logic [31:0] fb, input logic [31:0] zbb);
        h.x1 = a; h.x2 = b; h.y = yy; h.z1_in = za; h.z2_in = zb;
        h.rgbx_in = c; h.fb_base = fb; h.zbuff_base = zbb;
        h.start = 1'b1;
        step();
        h.start = 1'b0;
    endtask
    task automatic wait_out(input int lat);
        int n = 0;
        while (!h.start_out && n < 100) begin
            step();
            n++;
        end
        chk("latency", n, lat);
    endtask
    task automatic chk_res(input logic [31:0] edx, input logic [31:0] es, input logic [31:0] er,
                           input logic [31:0] ee, input logic [31:0] efb, input logic [31:0] ezb,
                           input logic [31:0] ez, input logic [31:0] ec);
        chk("dx", h.dx, edx);
        chk("slope", h.slope, es);
        chk("rem", h.rem, er);
        chk("err", h.err, ee);
        chk("fb_addr", h.fb_addr, efb);
        chk("zbuff_addr", h.zbuff_addr, ezb);
        chk("z1", h.z1, ez);
        chk("rgbx", h.rgbx, ec);
        chk("ready_busy", 32'(h.ready), 32'd0);
    endtask
    task automatic finish_span();
        h.done_in = 1'b1;
        step();
        h.done_in = 1'b0;
        chk("start_out_drop", 32'(h.start_out), 32'd0);
        chk("ready_back", 32'(h.ready), 32'd1);
    endtask
    initial begin
        h.start = 0; h.done_in = 0; h.x1 = 0; h.x2 = 0; h.y = 0;
        h.z1_in = 0; h.z2_in = 0; h.rgbx_in = 0; h.fb_base = 0; h.zbuff_base = 0;
        repeat (2) step();
        chk("rst_ready", 32'(h.ready), 32'd1);
        chk("rst_start_out", 32'(h.start_out), 32'd0);
        chk("rst_dx", h.dx, 32'd0);
        chk("rst_slope", h.slope, 32'd0);
        chk("rst_fb", h.fb_addr, 32'd0);
        reset = 1'b0;
        step();
        // basic span, then hold done low and check stability
        launch(0, 256, 0, 0, 32'hFFFFFFFF, 32'hDEADBEEF, 0, 32'h10000000);
        chk("accept_ready", 32'(h.ready), 32'd0);
        wait_out(33);
        chk_res(256, 32'h00FFFFFF, 255, 128, 0, 32'h10000000, 0, 32'hDEADBEEF);
        repeat (5) step();
        chk("hold_start_out", 32'(h.start_out), 32'd1);
        chk_res(256, 32'h00FFFFFF, 255, 128, 0, 32'h10000000, 0, 32'hDEADBEEF);
        finish_span();
        // wider span
        launch(0, 512, 0, 0, 32'hFFFFFFFF, 32'h01020304, 0, 32'h10000000);
        wait_out(33);
        chk_res(512, 32'h007FFFFF, 511, 256, 0, 32'h10000000, 0, 32'h01020304);
        finish_span();
        // swapped endpoints, row 2
        launch(266, 10, 2, 32'h00001000, 0, 32'h55AA55AA, 0, 32'h20000000);
        wait_out(33);
        chk_res(256, 16, 0, 128, 32'h00001428, 32'h20001428, 0, 32'h55AA55AA);
        finish_span();
        // zero length
        launch(5, 5, 0, 7, 9, 32'h11223344, 0, 32'h10000000);
        wait_out(1);
        chk_res(0, 0, 0, 0, 32'h14, 32'h10000014, 7, 32'h11223344);
        finish_span();
        // busy: start pulses and done pulse during DIV are ignored
        launch(0, 256, 0, 0, 32'hFFFFFFFF, 32'hDEADBEEF, 0, 32'h10000000);
        repeat (4) step();
        h.start = 1'b1; h.x2 = 100;
        step();
        h.start = 1'b0;
        chk("busy_ready5", 32'(h.ready), 32'd0);
        h.done_in = 1'b1;
        step();
        h.done_in = 1'b0;
        repeat (13) step();
        h.start = 1'b1;
        step();
        h.start = 1'b0;
        chk("busy_ready20", 32'(h.ready), 32'd0);
        wait_out(13);
        chk_res(256, 32'h00FFFFFF, 255, 128, 0, 32'h10000000, 0, 32'hDEADBEEF);
        finish_span();
        // async reset mid-divide
        launch(0, 512, 1, 0, 32'hFFFFFFFF, 32'hCAFEF00D, 32'h100, 32'h10000000);
        repeat (9) step();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(h.ready), 32'd1);
        chk("mid_rst_start_out", 32'(h.start_out), 32'd0);
        chk("mid_rst_dx", h.dx, 32'd0);
        chk("mid_rst_fb", h.fb_addr, 32'd0);
        chk("mid_rst_rgbx", h.rgbx, 32'd0);
        #2 reset = 1'b0;
        begin
            int seen = 0;
            repeat (40) begin
                step();
                if (h.start_out) seen++;
            end
            chk("no_pulse_after_rst", seen, 0);
        end
        launch(0, 512, 1, 0, 32'hFFFFFFFF, 32'hCAFEF00D, 32'h100, 32'h10000000);
        wait_out(33);
        chk_res(512, 32'h007FFFFF, 511, 256, 32'h00000B00, 32'h10000A00, 0, 32'hCAFEF00D);
        finish_span();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hline_setup.md
Name: hline_setup

Overview:
- Upstream setup stage for the horizontal-line z-buffer FSM.
- Accepts one span command: endpoints (x1, x2, y), depths (z1, z2) and colour rgbx.
- Orders the endpoints, computes pixel count dx, and derives the per-pixel z slope, remainder and initial error with an iterative restoring divider.
- Forms framebuffer and z-buffer start addresses, then presents the complete operand set to the line FSM and holds it until that FSM reports done.

Parameters:
- LINE_PIXELS, 640: pixels per scanline, used for address calculation.
- BPP_SHIFT, 2: log2 of bytes per pixel; the same value applies to framebuffer and z-buffer.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only when ready=1.
- ready  out  1  high in IDLE.
- x1  in  11  endpoint 1 x.
- x2  in  11  endpoint 2 x.
- y  in  10  scanline.
- z1_in  in  32  depth at x1.
- z2_in  in  32  depth at x2.
- rgbx_in  in  32  colour.
- fb_base  in  32  framebuffer base address.
- zbuff_base  in  32  z-buffer base address.
- done_in  in  1  line FSM has completed the span.
- start_out  out  1  operands valid; drives the line FSM start.
- fb_addr  out  32  framebuffer address of the first pixel.
- zbuff_addr  out  32  z-buffer address of the first pixel.
- dx  out  32  x_hi - x_lo, zero-extended.
- slope  out  32  dz / dx (quotient).
- rem  out  32  dz % dx.
- err  out  32  (dx + 1) >> 1.
- z1  out  32  depth at x_lo.
- rgbx  out  32  latched colour.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - start_out=0, ready=1.
  - All data outputs and internal registers go to 0.
- State set: IDLE, DIV, WAIT.
- IDLE:
  - ready=1.
  - On a clk edge with start=1, latch all inputs.
  - If x2 < x1, swap endpoints: x_lo=x2, z_lo=z2_in, z_hi=z1_in. Otherwise x_lo=x1, z_lo=z1_in, z_hi=z2_in.
  - dz = z_hi - z_lo, 32-bit unsigned, wraps.
  - dx = x_hi - x_lo.
  - Next state is DIV with count=31, or WAIT directly if dx==0 (slope=0, rem=0, err=0).
- Address arithmetic, registered in the same edge, 32-bit wrap:
  - fb_addr = fb_base + ((y*LINE_PIXELS + x_lo) << BPP_SHIFT).
  - zbuff_addr = zbuff_base + ((y*LINE_PIXELS + x_lo) << BPP_SHIFT).
- err is registered at load; z1 output = z_lo; rgbx output = rgbx_in.
- DIV: restoring division, one quotient bit per cycle, MSB first.
  - partial = {partial[31:0], dz[count]} (33-bit).
  - If partial >= dx: subtract dx and set quotient bit to 1; else set it to 0.
  - The division runs 32 cycles in total.
  - The edge with count==0 writes slope and rem and moves to WAIT.
- WAIT:
  - start_out=1; all data outputs held stable.
  - On done_in=1: start_out=0 at the next edge, then IDLE.
- Latency:
  - start_out rises at edge N+33 when start is sampled at edge N.
  - It rises at edge N+1 when dx==0.
- ready=0 outside IDLE. start asserted while not in IDLE is ignored; no queueing.
- done_in outside WAIT is ignored.
- done_in and start both high in WAIT: go to IDLE; start is not accepted that cycle.
- Reset during DIV or WAIT aborts the span. No start_out pulse follows.
- Data outputs change only at the IDLE-accept edge and the final DIV edge. The line FSM may sample them any time start_out=1.

Test Plan:
- Basic span:
  - Stimulus: x1=0, x2=256, y=0, z1_in=0, z2_in=32'hFFFFFFFF, fb_base=0, zbuff_base=32'h10000000, rgbx_in=32'hDEADBEEF.
  - Required: start_out rises 33 cycles after accept; dx=256, slope=32'h00FFFFFF, rem=255, err=128, fb_addr=0, zbuff_addr=32'h10000000, rgbx=32'hDEADBEEF.
  - Holding done_in low keeps the outputs stable; a one-cycle done_in pulse returns the block to IDLE with ready=1.
- Wider span:
  - Stimulus: x1=0, x2=512, same depths.
  - Required: dx=512, slope=32'h007FFFFF, rem=511, err=256.
- Swapped endpoints and addressing:
  - Stimulus: x1=266, x2=10, y=2, z1_in=32'h00001000, z2_in=0, fb_base=0.
  - Required: x_lo=10, z1=0, dx=256, slope=16, rem=0, err=128, fb_addr=32'h00001428.
- Zero length:
  - Stimulus: x1=x2=5.
  - Required: start_out one cycle after accept; dx=0, slope=0, rem=0, err=0; no divide-by-zero hazard.
- Busy and late handshake:
  - Stimulus: pulse start in cycles 5 and 20 of DIV, and pulse done_in during DIV.
  - Required: both ignored; the original results are unchanged; ready stays 0 until done_in arrives in WAIT.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously (between edges) during DIV cycle 10.
  - Required: outputs go to 0 immediately, start_out=0, ready=1. A subsequent command completes normally with correct results.
